// File: rtl/sreg_slave_pkg.sv
// sreg_slave shared types: state encoding, RW codes, index width helper.
// Optional feature macro: SREG_SLAVE_PARITY_EN (adds a PAR bit after DATA).
package sreg_slave_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_CTRL,
      S_RD,
      S_WR,
      S_SKIP
   } state_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

`ifdef SREG_SLAVE_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

   function automatic int idx_width(input int nreg);
      return (nreg > 2) ? $clog2(nreg) : 1;
   endfunction

endpackage

// File: rtl/sreg_slave_regfile.sv
// sreg_slave register array: NREG x DATA_W, one write port,
// one combinational read port, cleared by async reset.
module sreg_slave_regfile #(
   parameter int NREG   = 4,
   parameter int DATA_W = 8,
   parameter int IDX_W  = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [IDX_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [NREG];

   // Register storage: clear on reset, single write per cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = (int'(raddr_i) < NREG) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/sreg_slave.sv
// sreg_slave: serial addressed register slave (ADDR, RW, IDX, DATA[, PAR]).
// Optional feature macro: SREG_SLAVE_PARITY_EN (PAR bit and PERR port).
module sreg_slave
   import sreg_slave_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int NREG   = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              RX,
   input  logic              FS,
   input  logic [ADDR_W-1:0] ADDR_CFG,
   output logic              TX,
   output logic              TX_EN,
   output logic              WR_STB,
`ifdef SREG_SLAVE_PARITY_EN
   output logic              PERR,
`endif
   output logic              BUSY
);

   localparam int IDX_W = idx_width(NREG);
   localparam int CTL_W = IDX_W + 1;
   localparam int BODY  = DATA_W + PAR_W;
   localparam int F     = ADDR_W + CTL_W + BODY;
   localparam int CNT_W = $clog2(F);
   localparam int DQ_W  = DATA_W - 1 + PAR_W;
   localparam logic [IDX_W:0] NREG_V = (IDX_W + 1)'(NREG);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-2:0]   addr_q, addr_d;
   logic [CTL_W-2:0]    ctl_q, ctl_d;
   logic [DQ_W-1:0]     dat_q, dat_d;
   logic [DATA_W-1:0]   rd_q, rd_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                tx_q, tx_d;
   logic                en_q, en_d;
   logic                stb_q, stb_d;
`ifdef SREG_SLAVE_PARITY_EN
   logic                perr_q, perr_d;
`endif

   logic [ADDR_W-1:0]   addr_full;
   logic [CTL_W-1:0]    ctl_full;
   logic [IDX_W-1:0]    idx_full;
   logic                rw_full;
   logic                idx_ok;
   logic [DATA_W-1:0]   dat_full;
   logic [DATA_W-1:0]   rdata;
   logic                par_rd;
   logic                we;
   logic [DATA_W-1:0]   wdata;

   // Fields completed by the bit arriving this cycle
   assign addr_full = {RX, addr_q};
   assign ctl_full  = {RX, ctl_q};
   assign idx_full  = ctl_full[CTL_W-1:1];
   assign rw_full   = ctl_full[0];
   assign idx_ok    = {1'b0, idx_full} < NREG_V;

`ifdef SREG_SLAVE_PARITY_EN
   assign dat_full = {RX, dat_q[DATA_W-1:1]};
   assign par_rd   = ^rdata;
`else
   assign dat_full = {RX, dat_q};
   assign par_rd   = 1'b0;
`endif

   sreg_slave_regfile #(
      .NREG   (NREG),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_regfile (
      .clk_i   (CLK),
      .rst_i   (RST),
      .we_i    (we),
      .waddr_i (idx_q),
      .wdata_i (wdata),
      .raddr_i (idx_full),
      .rdata_o (rdata)
   );

   // Frame decoder: next state, shifters, read serializer, write commit
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - CNT_W'(1);
      addr_d  = addr_q;
      ctl_d   = ctl_q;
      dat_d   = dat_q;
      rd_d    = rd_q;
      idx_d   = idx_q;
      tx_d    = 1'b0;
      en_d    = 1'b0;
      stb_d   = 1'b0;
      we      = 1'b0;
      wdata   = dat_full;
`ifdef SREG_SLAVE_PARITY_EN
      perr_d  = 1'b0;
`endif
      if (FS) begin
         state_d = S_ADDR;
         cnt_d   = CNT_W'(ADDR_W - 2);
         addr_d  = addr_full[ADDR_W-1:1];
      end else begin
         unique case (state_q)
            S_IDLE: begin
               cnt_d = '0;
            end
            S_ADDR: begin
               addr_d = addr_full[ADDR_W-1:1];
               if (cnt_q == '0) begin
                  if (addr_full == ADDR_CFG) begin
                     state_d = S_CTRL;
                     cnt_d   = CNT_W'(IDX_W);
                  end else begin
                     state_d = S_SKIP;
                     cnt_d   = CNT_W'(F - ADDR_W - 1);
                  end
               end
            end
            S_CTRL: begin
               ctl_d = ctl_full[CTL_W-1:1];
               if (cnt_q == '0) begin
                  idx_d = idx_full;
                  cnt_d = CNT_W'(BODY - 1);
                  if (!idx_ok) begin
                     state_d = S_SKIP;
                  end else if (rw_full == RW_READ) begin
                     state_d = S_RD;
                     tx_d    = rdata[0];
                     en_d    = 1'b1;
                     rd_d    = {par_rd, rdata[DATA_W-1:1]};
                  end else begin
                     state_d = S_WR;
                  end
               end
            end
            S_RD: begin
               if (cnt_q == '0) begin
                  state_d = S_IDLE;
               end else begin
                  tx_d = rd_q[0];
                  en_d = 1'b1;
                  rd_d = rd_q >> 1;
               end
            end
            S_WR: begin
`ifdef SREG_SLAVE_PARITY_EN
               if (cnt_q == '0) begin
                  state_d = S_IDLE;
                  if (RX == ^dat_q) begin
                     we    = 1'b1;
                     wdata = dat_q;
                     stb_d = 1'b1;
                  end else begin
                     perr_d = 1'b1;
                  end
               end else begin
                  dat_d = dat_full;
               end
`else
               dat_d = dat_full[DATA_W-1:1];
               if (cnt_q == '0) begin
                  state_d = S_IDLE;
                  we      = 1'b1;
                  stb_d   = 1'b1;
               end
`endif
            end
            S_SKIP: begin
               if (cnt_q == '0) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Frame state, shift registers and registered outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         ctl_q   <= '0;
         dat_q   <= '0;
         rd_q    <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b0;
         en_q    <= 1'b0;
         stb_q   <= 1'b0;
`ifdef SREG_SLAVE_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         ctl_q   <= ctl_d;
         dat_q   <= dat_d;
         rd_q    <= rd_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         en_q    <= en_d;
         stb_q   <= stb_d;
`ifdef SREG_SLAVE_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign TX     = tx_q;
   assign TX_EN  = en_q;
   assign WR_STB = stb_q;
   assign BUSY   = ~RST & (FS | (state_q != S_IDLE));
`ifdef SREG_SLAVE_PARITY_EN
   assign PERR   = perr_q;
`endif

endmodule
